regfile_cmd_arbiter: RTL and testbench
======================================

// Module: regfile_cmd_arbiter
// PURPOSE
//  Shares one RegisterFile (8 x 32-bit: R1-R4, S1-S4) between NREQ command requesters.
//  Accepts WRITE / READ / COPY commands over valid/ready, arbitrates, and drives the RF controls.
//  Controls driven: I, FunSel, RegSel, ScrSel, OutASel, OutBSel.
//  Returns one response per command. Sits between the control unit / DMA-style masters and the RF.
// PARAMETERS
//  NREQ   2   number of requesters (2..4)
//  DW     32  data width; must match RF I/OutA/OutB
// PORTS
//  Clock      in   1         single clock, rising edge
//  Reset      in   1         asynchronous, active-low reset
//  req_valid  in   NREQ      command valid, one bit per requester
//  req_ready  out  NREQ      command accepted this cycle (combinational from arbitration)
//  req_op     in   2*NREQ    per-requester opcode: OP_WRITE/OP_READ/OP_COPY
//  req_fun    in   3*NREQ    FunSel for OP_WRITE
//  req_dst    in   8*NREQ    destination mask {RegSel[3:0],ScrSel[3:0]}
//  req_srca   in   3*NREQ    OutASel source (READ, COPY)
//  req_srcb   in   3*NREQ    OutBSel source (READ)
//  req_data   in   DW*NREQ   write data for OP_WRITE
//  rf_I       out  DW        to RF I
//  rf_FunSel  out  3         to RF FunSel
//  rf_RegSel  out  4         to RF RegSel
//  rf_ScrSel  out  4         to RF ScrSel
//  rf_OutASel out  3         to RF OutASel
//  rf_OutBSel out  3         to RF OutBSel
//  rf_OutA    in   DW        from RF OutA
//  rf_OutB    in   DW        from RF OutB
//  rsp_valid  out  1         one-cycle completion pulse, registered
//  rsp_id     out  clog2(NREQ) requester that completed
//  rsp_a      out  DW        sampled OutA (READ, COPY); 0 for WRITE
//  rsp_b      out  DW        sampled OutB (READ); 0 otherwise
// BEHAVIOUR
//  Reset
//   - state=IDLE, rr_ptr=0, rsp_*=0.
//   - All rf_* outputs =0 with RegSel/ScrSel=0, so no RF write occurs.
//  Idle cycles (no grant, not COPY2)
//   - rf_RegSel=rf_ScrSel=0, rf_FunSel=0, rf_I=0; OutASel/OutBSel hold last value.
//  FSM IDLE
//   - Round-robin grant starting at rr_ptr; req_ready[g]=1 for the granted requester only.
//   - WRITE: same cycle drives FunSel=req_fun, RegSel/ScrSel=req_dst, I=req_data.
//     RF updates at that edge; rsp_valid next cycle.
//   - READ: same cycle drives OutASel=srca, OutBSel=srcb; registers OutA/OutB into rsp_a/rsp_b.
//     rsp_valid next cycle; no RF write.
//   - COPY: cycle G drives OutASel=srca and captures OutA into tmp; next state COPY2.
//  FSM COPY2
//   - Drives I=tmp, FunSel=FUNSEL_LOAD, RegSel/ScrSel=req_dst (latched); all req_ready=0.
//   - rsp_valid next cycle with rsp_a=tmp -> IDLE.
//  Arbitration
//   - rr_ptr <= grant+1 (mod NREQ) on every grant; no request waits more than NREQ grants.
//  Boundaries
//   - dst mask =0: legal no-op, still responds.
//   - COPY with src in dst: loads the pre-copy value.
//   - valid dropped before ready: no effect.
//   - Reset asserted in COPY2: aborts with no write, no rsp.
//   - Back-to-back grants: one per cycle; COPY occupies 2.
// CONFIGURATION
//  RF_ARB_FIXED_PRIO_EN
//   - defined: fixed priority, requester 0 highest; rr_ptr removed.
//   - undefined (default): round-robin as above.
// STRUCTURE
//  Package regfile_arb_pkg
//   - OP_WRITE=2'd0, OP_READ=2'd1, OP_COPY=2'd2 (2'd3 treated as no-op with response).
//   - FUNSEL_LOAD, encoding identical to Register32bit.
//   - RF select codes R1..S4 = 3'd0..3'd7; state enum {IDLE, COPY2}.
//  Sub-module rr_arbiter (NREQ-wide req -> one-hot grant, rr_ptr update).
// TESTING
//  - Reset low mid-run -> all rf_RegSel/ScrSel=0, rsp_valid=0, state IDLE next cycle.
//  - Req0 WRITE FunSel=LOAD dst=8'b1000_0000 data=0xDEADBEEF
//    -> R1=0xDEADBEEF; rsp_valid id=0 one cycle later.
//  - Req0 READ srca=0 srcb=3 after R4=0x12345678 -> rsp_a=0xDEADBEEF, rsp_b=0x12345678.
//  - Req1 COPY srca=0 dst=8'b0000_0001 (S4) -> req_ready low 1 cycle; S4=0xDEADBEEF;
//    rsp at G+2.
//  - Both valid continuously with WRITEs -> grants alternate 0,1,0,1
//    (fixed-prio build: always 0).
//  - Reset asserted during COPY2 -> S4 unchanged, no rsp_valid.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Package: regfile_arb_pkg
// Opcodes, RF function/select codes, FSM state codes and the decoded command
// record shared by regfile_cmd_arbiter and its round-robin arbiter.
package regfile_arb_pkg;

  // Command opcodes; OP_NOP is answered with an all-zero response.
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_COPY  = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  // Register32bit FunSel encoding.
  localparam logic [2:0] FUNSEL_DEC  = 3'b000;
  localparam logic [2:0] FUNSEL_INC  = 3'b001;
  localparam logic [2:0] FUNSEL_LOAD = 3'b010;
  localparam logic [2:0] FUNSEL_CLR  = 3'b011;

  // OutASel / OutBSel source codes.
  localparam logic [2:0] SEL_R1 = 3'd0;
  localparam logic [2:0] SEL_R2 = 3'd1;
  localparam logic [2:0] SEL_R3 = 3'd2;
  localparam logic [2:0] SEL_R4 = 3'd3;
  localparam logic [2:0] SEL_S1 = 3'd4;
  localparam logic [2:0] SEL_S2 = 3'd5;
  localparam logic [2:0] SEL_S3 = 3'd6;
  localparam logic [2:0] SEL_S4 = 3'd7;

  // FSM state codes: IDLE arbitrates, COPY2 performs the write half of a COPY.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COPY2 = 1'b1;

  // One requester's command fields, without the write data.
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] fun;
    logic [7:0] dst;
    logic [2:0] srca;
    logic [2:0] srcb;
  } cmd_t;

  // Destination mask is {RegSel[3:0], ScrSel[3:0]}; bit 7 is R1, bit 0 is S4.
  function automatic logic [3:0] dst_regsel(input logic [7:0] dst);
    return dst[7:4];
  endfunction

  function automatic logic [3:0] dst_scrsel(input logic [7:0] dst);
    return dst[3:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Module: rr_arbiter
// NREQ-wide request vector -> one-hot grant plus grant index.
// Default build: round-robin, search starts at rr_ptr_q, which moves to
// grant+1 (mod NREQ) on every grant.
// Build macro RF_ARB_FIXED_PRIO_EN: fixed priority, requester 0 highest,
// no pointer state.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            gnt_valid_o
);

`ifdef RF_ARB_FIXED_PRIO_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // Lowest-numbered valid requester wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_valid_o && req_i[k]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'(k);
        gnt_o[k]    = 1'b1;
      end else begin
        gnt_valid_o = gnt_valid_o;
      end
    end
  end

`else

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  logic [IW-1:0] cand;

  // First valid requester at or after rr_ptr_q wins; pointer moves past it.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o   = 1'b1;
        gnt_idx_o     = cand;
        gnt_o[cand]   = 1'b1;
      end else begin
        gnt_valid_o = gnt_valid_o;
      end
    end
    if (gnt_valid_o) begin
      rr_ptr_d = IW'((int'(gnt_idx_o) + 1) % NREQ);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`endif

endmodule

// File: rtl/regfile_cmd_arbiter.sv
// Module: regfile_cmd_arbiter
// Shares one 8 x DW RegisterFile (R1-R4, S1-S4) between NREQ requesters.
// WRITE and READ take one grant cycle; COPY takes the grant cycle (read into
// tmp) plus a COPY2 cycle (load tmp into the destination). Every command
// produces one registered rsp_valid pulse the cycle after it completes.
// Build macro RF_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module regfile_cmd_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [3*NREQ-1:0]        req_fun,
  input  logic [8*NREQ-1:0]        req_dst,
  input  logic [3*NREQ-1:0]        req_srca,
  input  logic [3*NREQ-1:0]        req_srcb,
  input  logic [DW*NREQ-1:0]       req_data,
  output logic [DW-1:0]            rf_I,
  output logic [2:0]               rf_FunSel,
  output logic [3:0]               rf_RegSel,
  output logic [3:0]               rf_ScrSel,
  output logic [2:0]               rf_OutASel,
  output logic [2:0]               rf_OutBSel,
  input  logic [DW-1:0]            rf_OutA,
  input  logic [DW-1:0]            rf_OutB,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DW-1:0]            rsp_a,
  output logic [DW-1:0]            rsp_b
);

  localparam int IW = $clog2(NREQ);

  // Per-requester views of the flat command buses.
  cmd_t          cmd_a  [NREQ];
  logic [DW-1:0] data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cmd_a[g] = '{op:   req_op[2*g +: 2],
                        fun:  req_fun[3*g +: 3],
                        dst:  req_dst[8*g +: 8],
                        srca: req_srca[3*g +: 3],
                        srcb: req_srcb[3*g +: 3]};
    assign data_a[g] = req_data[DW*g +: DW];
  end

  // FSM and datapath state.
  logic [0:0]    state_q,     state_d;
  logic [DW-1:0] tmp_q,       tmp_d;
  logic [7:0]    dst_q,       dst_d;
  logic [IW-1:0] cid_q,       cid_d;
  logic [2:0]    outa_sel_q,  outa_sel_d;
  logic [2:0]    outb_sel_q,  outb_sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q,    rsp_id_d;
  logic [DW-1:0] rsp_a_q,     rsp_a_d;
  logic [DW-1:0] rsp_b_q,     rsp_b_d;

  // Arbitration only while IDLE and out of reset, so COPY2 and reset never grant.
  logic            arb_en;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_valid;
  cmd_t            sel_cmd;
  logic [DW-1:0]   sel_data;

  assign arb_en   = rst_n & (state_q == ST_IDLE);
  assign arb_req  = req_valid & {NREQ{arb_en}};
  assign sel_cmd  = cmd_a[gnt_idx];
  assign sel_data = data_a[gnt_idx];
  assign req_ready = gnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (arb_req),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // Command execution: same-cycle RF drive, next-state and response capture.
  always_comb begin
    state_d     = state_q;
    tmp_d       = tmp_q;
    dst_d       = dst_q;
    cid_d       = cid_q;
    outa_sel_d  = outa_sel_q;
    outb_sel_d  = outb_sel_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_a_d     = '0;
    rsp_b_d     = '0;
    rf_I        = '0;
    rf_FunSel   = 3'b000;
    rf_RegSel   = 4'b0000;
    rf_ScrSel   = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          case (sel_cmd.op)
            OP_WRITE: begin
              rf_I        = sel_data;
              rf_FunSel   = sel_cmd.fun;
              rf_RegSel   = dst_regsel(sel_cmd.dst);
              rf_ScrSel   = dst_scrsel(sel_cmd.dst);
              rsp_valid_d = 1'b1;
              rsp_id_d    = gnt_idx;
            end
            OP_READ: begin
              outa_sel_d  = sel_cmd.srca;
              outb_sel_d  = sel_cmd.srcb;
              rsp_valid_d = 1'b1;
              rsp_id_d    = gnt_idx;
              rsp_a_d     = rf_OutA;
              rsp_b_d     = rf_OutB;
            end
            OP_COPY: begin
              // Source is sampled now, before any write, so src-in-dst copies the old value.
              outa_sel_d = sel_cmd.srca;
              tmp_d      = rf_OutA;
              dst_d      = sel_cmd.dst;
              cid_d      = gnt_idx;
              state_d    = ST_COPY2;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_id_d    = gnt_idx;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COPY2: begin
        rf_I        = tmp_q;
        rf_FunSel   = FUNSEL_LOAD;
        rf_RegSel   = dst_regsel(dst_q);
        rf_ScrSel   = dst_scrsel(dst_q);
        rsp_valid_d = 1'b1;
        rsp_id_d    = cid_q;
        rsp_a_d     = tmp_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rf_OutASel = outa_sel_d;
    rf_OutBSel = outb_sel_d;
  end

  // State, copy buffer, held read selects and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmp_q       <= '0;
      dst_q       <= 8'h00;
      cid_q       <= '0;
      outa_sel_q  <= 3'd0;
      outb_sel_q  <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      tmp_q       <= tmp_d;
      dst_q       <= dst_d;
      cid_q       <= cid_d;
      outa_sel_q  <= outa_sel_d;
      outb_sel_q  <= outb_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;

endmodule

// File: tb/tb_regfile_cmd_arbiter.sv
// Testbench for regfile_cmd_arbiter: behavioural RF plus a transaction-level
// reference model checked every cycle, a directed scenario with literal
// expectations, then randomized traffic with occasional resets.
module tb_regfile_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [2*NREQ-1:0]       req_op;
  logic [3*NREQ-1:0]       req_fun;
  logic [8*NREQ-1:0]       req_dst;
  logic [3*NREQ-1:0]       req_srca;
  logic [3*NREQ-1:0]       req_srcb;
  logic [DW*NREQ-1:0]      req_data;
  logic [DW-1:0]           rf_I;
  logic [2:0]              rf_FunSel;
  logic [3:0]              rf_RegSel;
  logic [3:0]              rf_ScrSel;
  logic [2:0]              rf_OutASel;
  logic [2:0]              rf_OutBSel;
  logic [DW-1:0]           rf_OutA;
  logic [DW-1:0]           rf_OutB;
  logic                    rsp_valid;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [DW-1:0]           rsp_a;
  logic [DW-1:0]           rsp_b;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_cmd_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_fun(req_fun), .req_dst(req_dst),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_data(req_data),
    .rf_I(rf_I), .rf_FunSel(rf_FunSel), .rf_RegSel(rf_RegSel), .rf_ScrSel(rf_ScrSel),
    .rf_OutASel(rf_OutASel), .rf_OutBSel(rf_OutBSel),
    .rf_OutA(rf_OutA), .rf_OutB(rf_OutB),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_a(rsp_a), .rsp_b(rsp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: index 0..3 = R1..R4, 4..7 = S1..S4.
  logic [DW-1:0] rf_mem [8];
  logic [7:0]    rf_mask;
  assign rf_mask = {rf_RegSel, rf_ScrSel};
  assign rf_OutA = rf_mem[rf_OutASel];
  assign rf_OutB = rf_mem[rf_OutBSel];

  initial begin
    for (int r = 0; r < 8; r++) rf_mem[r] = '0;
  end

  always @(posedge clk) begin
    for (int r = 0; r < 8; r++) begin
      if (rf_mask[7-r]) begin
        case (rf_FunSel)
          3'd0:    rf_mem[r] <= rf_mem[r] - 32'd1;
          3'd1:    rf_mem[r] <= rf_mem[r] + 32'd1;
          3'd2:    rf_mem[r] <= rf_I;
          3'd3:    rf_mem[r] <= '0;
          default: rf_mem[r] <= rf_mem[r];
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who goes next, pending copy write, expected response.
  int            m_start;
  bit            m_copy;
  int            m_cid;
  logic [7:0]    m_cdst;
  logic [DW-1:0] m_tmp;
  logic [2:0]    m_lasta, m_lastb;
  bit            e_rv;
  int            e_id;
  logic [DW-1:0] e_a, e_b;

  initial begin : compare_proc
    int            g;
    int            idx;
    logic [NREQ-1:0] x_ready;
    logic [DW-1:0] x_I;
    logic [2:0]    x_fun, x_a, x_b;
    logic [7:0]    x_dst;
    bit            n_rv;
    int            n_id;
    logic [DW-1:0] n_a, n_b;
    logic [1:0]    op;
    m_start = 0; m_copy = 0; m_cid = 0; m_cdst = 8'h00; m_tmp = '0;
    m_lasta = 3'd0; m_lastb = 3'd0;
    e_rv = 0; e_id = 0; e_a = '0; e_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ready", req_ready, 64'd0);
        chk("rst_ctrl", {rf_I, rf_FunSel, rf_RegSel, rf_ScrSel, rf_OutASel, rf_OutBSel}, 64'd0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_a}, 64'd0);
        chk("rst_rsp_b", rsp_b, 64'd0);
        m_start = 0; m_copy = 0; m_lasta = 3'd0; m_lastb = 3'd0;
        e_rv = 0; e_id = 0; e_a = '0; e_b = '0;
      end else begin
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_id", rsp_id, e_id);
        chk("rsp_a", rsp_a, e_a);
        chk("rsp_b", rsp_b, e_b);
        x_ready = '0; x_I = '0; x_fun = 3'd0; x_dst = 8'h00;
        x_a = m_lasta; x_b = m_lastb;
        n_rv = 0; n_id = 0; n_a = '0; n_b = '0;
        if (m_copy) begin
          x_I = m_tmp; x_fun = 3'b010; x_dst = m_cdst;
          n_rv = 1; n_id = m_cid; n_a = m_tmp;
          m_copy = 0;
        end else begin
          g = -1;
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_start + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
          end
          if (g >= 0) begin
            x_ready[g] = 1'b1;
`ifdef RF_ARB_FIXED_PRIO_EN
            m_start = 0;
`else
            m_start = (g + 1) % NREQ;
`endif
            op = req_op[2*g +: 2];
            if (op == 2'd0) begin
              x_I = req_data[DW*g +: DW]; x_fun = req_fun[3*g +: 3]; x_dst = req_dst[8*g +: 8];
              n_rv = 1; n_id = g;
            end else if (op == 2'd1) begin
              x_a = req_srca[3*g +: 3]; x_b = req_srcb[3*g +: 3];
              n_rv = 1; n_id = g; n_a = rf_mem[x_a]; n_b = rf_mem[x_b];
            end else if (op == 2'd2) begin
              x_a = req_srca[3*g +: 3];
              m_tmp = rf_mem[x_a]; m_cdst = req_dst[8*g +: 8]; m_cid = g; m_copy = 1;
            end else begin
              n_rv = 1; n_id = g;
            end
          end
        end
        m_lasta = x_a; m_lastb = x_b;
        chk("req_ready", req_ready, x_ready);
        chk("rf_I", rf_I, x_I);
        chk("rf_FunSel", rf_FunSel, x_fun);
        chk("rf_dst", {rf_RegSel, rf_ScrSel}, x_dst);
        chk("rf_OutASel", rf_OutASel, x_a);
        chk("rf_OutBSel", rf_OutBSel, x_b);
        e_rv = n_rv; e_id = n_id; e_a = n_a; e_b = n_b;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [2:0] fun,
                         input logic [7:0] dst, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [DW-1:0] d);
    req_valid[r]            = 1'b1;
    req_op[2*r +: 2]        = op;
    req_fun[3*r +: 3]       = fun;
    req_dst[8*r +: 8]       = dst;
    req_srca[3*r +: 3]      = sa;
    req_srcb[3*r +: 3]      = sb;
    req_data[DW*r +: DW]    = d;
  endtask

  initial begin : stimulus
    logic [NREQ-1:0] exp_gnt;
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_fun = '0; req_dst = '0;
    req_srca = '0; req_srcb = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t_reset_rsp", rsp_valid, 64'd0);
    chk("t_reset_sel", {rf_RegSel, rf_ScrSel}, 64'd0);

    // Req0 WRITE LOAD R1 = DEADBEEF.
    step(); set_req(0, 2'd0, 3'b010, 8'b1000_0000, 3'd0, 3'd0, 32'hDEADBEEF);
    @(negedge clk);
    chk("t_wr_ready", req_ready, 64'b01);
    chk("t_wr_regsel", rf_RegSel, 64'b1000);
    chk("t_wr_I", rf_I, 64'hDEADBEEF);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t_wr_rsp", {rsp_valid, rsp_id}, 64'b10);
    chk("t_wr_R1", rf_mem[0], 64'hDEADBEEF);

    // R4 = 12345678, then READ R1/R4.
    step(); set_req(0, 2'd0, 3'b010, 8'b0001_0000, 3'd0, 3'd0, 32'h12345678);
    step(); set_req(0, 2'd1, 3'b000, 8'h00, 3'd0, 3'd3, 32'h0);
    @(negedge clk);
    chk("t_rd_sel", {rf_OutASel, rf_OutBSel}, 64'b000_011);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t_rd_valid", rsp_valid, 64'd1);
    chk("t_rd_a", rsp_a, 64'hDEADBEEF);
    chk("t_rd_b", rsp_b, 64'h12345678);

    // Req1 COPY R1 -> S4; two-cycle occupancy.
    step(); set_req(1, 2'd2, 3'b000, 8'b0000_0001, 3'd0, 3'd0, 32'h0);
    @(negedge clk);
    chk("t_cp_g_ready", req_ready, 64'b10);
    step(); set_req(0, 2'd0, 3'b010, 8'h00, 3'd0, 3'd0, 32'h0);
    @(negedge clk);
    chk("t_cp2_ready", req_ready, 64'b00);
    chk("t_cp2_ctrl", {rf_FunSel, rf_RegSel, rf_ScrSel}, 64'b010_0000_0001);
    chk("t_cp2_I", rf_I, 64'hDEADBEEF);
    chk("t_cp2_norsp", rsp_valid, 64'd0);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t_cp_rsp", {rsp_valid, rsp_id}, 64'b11);
    chk("t_cp_a", rsp_a, 64'hDEADBEEF);
    chk("t_cp_S4", rf_mem[7], 64'hDEADBEEF);

    // Both requesters write continuously.
    step();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 2'd0, 3'b010, 8'h00, 3'd0, 3'd0, 32'(i));
      set_req(1, 2'd0, 3'b010, 8'b0000_1000, 3'd0, 3'd0, 32'(100 + i));
      @(negedge clk);
`ifdef RF_ARB_FIXED_PRIO_EN
      exp_gnt = 2'b01;
`else
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("t_alt_grant", req_ready, exp_gnt);
      step();
    end
    req_valid = '0;

    // COPY R4 -> S4 aborted by reset in COPY2.
    step(); set_req(0, 2'd2, 3'b000, 8'b0000_0001, 3'd3, 3'd0, 32'h0);
    @(negedge clk);
    chk("t_ab_ready", req_ready, 64'b01);
    step(); rst_n = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("t_ab_sel", {rf_RegSel, rf_ScrSel}, 64'd0);
    chk("t_ab_norsp", rsp_valid, 64'd0);
    step();
    @(negedge clk);
    chk("t_ab_S4", rf_mem[7], 64'hDEADBEEF);
    chk("t_ab_norsp2", rsp_valid, 64'd0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("t_ab_norsp3", rsp_valid, 64'd0);

    // Randomized traffic with sporadic resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      for (int r = 0; r < NREQ; r++) begin
        set_req(r, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 8'($urandom),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 32'($urandom));
        req_valid[r] = ($urandom_range(0, 2) != 0);
      end
    end
    step(); rst_n = 1'b1; req_valid = '0;
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
